// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue feeding the 32x64 register file write port, with a pending-write
// scoreboard. Define FWD_EN to add two combinational lookup ports that forward queued data.
module regfile_writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned CNT_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_dest,
  input  logic [63:0]       in_data,
  input  logic              hold,
`ifdef FWD_EN
  input  logic [4:0]        fwd_a_sel,
  input  logic [4:0]        fwd_b_sel,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [63:0]       fwd_a_data,
  output logic [63:0]       fwd_b_data,
`endif
  output logic              rf_write,
  output logic [4:0]        rf_select,
  output logic [63:0]       rf_data,
  output logic [31:0]       pending,
  output logic [CNT_W-1:0]  count,
  output logic              busy
);

  logic [4:0]       mem_dest_q [DEPTH];
  logic [4:0]       mem_dest_d [DEPTH];
  logic [63:0]      mem_data_q [DEPTH];
  logic [63:0]      mem_data_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] entry_valid;
  logic             accept, push, pop;

  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign accept   = in_valid & in_ready;
  // Register 31 is hardwired zero: complete the handshake but drop the request.
  assign push     = accept & (in_dest != 5'd31);
  assign busy     = (count_q != '0);
  assign rf_write = busy & ~hold;
  assign pop      = rf_write;
  assign count    = count_q;

  always_comb begin
    rf_select = '0;
    rf_data   = '0;
    if (busy) begin
      rf_select = mem_dest_q[rd_ptr_q];
      rf_data   = mem_data_q[rd_ptr_q];
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] age;
    entry_valid = '0;
    pending     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age            = PTR_W'(i) - rd_ptr_q;
      entry_valid[i] = CNT_W'(age) < count_q;
      if (entry_valid[i]) pending[mem_dest_q[i]] = 1'b1;
    end
    pending[31] = 1'b0;
  end

  always_comb begin
    mem_dest_d = mem_dest_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_dest_d[wr_ptr_q] = in_dest;
      mem_data_d[wr_ptr_q] = in_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_dest_q[i] <= '0;
        mem_data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_dest_q <= mem_dest_d;
      mem_data_q <= mem_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

`ifdef FWD_EN
  // Walk oldest to youngest so the last match is the youngest writer.
  function automatic logic [64:0] lookup(input logic [4:0] sel);
    logic [PTR_W-1:0] idx;
    logic [64:0]      res;
    res = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (mem_dest_q[idx] == sel) && (sel != 5'd31)) begin
        res = {1'b1, mem_data_q[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {fwd_a_hit, fwd_a_data} = lookup(fwd_a_sel);
    {fwd_b_hit, fwd_b_data} = lookup(fwd_b_sel);
  end
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue; lookup checks are built when FWD_EN is defined.
module tb_regfile_writeback_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_dest;
  logic [63:0] in_data;
  logic        hold;
  logic        rf_write;
  logic [4:0]  rf_select;
  logic [63:0] rf_data;
  logic [31:0] pending;
  logic [2:0]  count;
  logic        busy;
`ifdef FWD_EN
  logic [4:0]  fwd_a_sel, fwd_b_sel;
  logic        fwd_a_hit, fwd_b_hit;
  logic [63:0] fwd_a_data, fwd_b_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  regfile_writeback_queue #(.DEPTH(4), .PTR_W(2), .CNT_W(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .hold      (hold),
`ifdef FWD_EN
    .fwd_a_sel (fwd_a_sel),
    .fwd_b_sel (fwd_b_sel),
    .fwd_a_hit (fwd_a_hit),
    .fwd_b_hit (fwd_b_hit),
    .fwd_a_data(fwd_a_data),
    .fwd_b_data(fwd_b_data),
`endif
    .rf_write  (rf_write),
    .rf_select (rf_select),
    .rf_data   (rf_data),
    .pending   (pending),
    .count     (count),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [4:0] d, input logic [63:0] v);
    in_valid = 1'b1;
    in_dest  = d;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 20000");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_dest  = '0;
    in_data  = '0;
    hold     = 1'b0;
`ifdef FWD_EN
    fwd_a_sel = '0;
    fwd_b_sel = '0;
`endif
    #12;
    check("rst_count",     64'(count), 64'd0);
    check("rst_busy",      64'(busy), 64'd0);
    check("rst_rf_write",  64'(rf_write), 64'd0);
    check("rst_rf_select", 64'(rf_select), 64'd0);
    check("rst_rf_data",   rf_data, 64'd0);
    check("rst_pending",   64'(pending), 64'd0);
    check("rst_in_ready",  64'(in_ready), 64'd1);
    reset = 1'b1;

    // Single write: no same-cycle bypass, write the cycle after acceptance
    in_valid = 1'b1; in_dest = 5'd5; in_data = 64'h1234;
    settle();
    check("sw_ready", 64'(in_ready), 64'd1);
    check("sw_no_bypass", 64'(rf_write), 64'd0);
    tick();
    in_valid = 1'b0;
    settle();
    check("sw_write",   64'(rf_write), 64'd1);
    check("sw_select",  64'(rf_select), 64'd5);
    check("sw_data",    rf_data, 64'h1234);
    check("sw_pending", 64'(pending), 64'h20);
    check("sw_count",   64'(count), 64'd1);
    tick();
    check("sw_count_after",   64'(count), 64'd0);
    check("sw_pending_after", 64'(pending), 64'd0);
    check("sw_write_after",   64'(rf_write), 64'd0);

    // Zero register request is accepted but dropped
    in_valid = 1'b1; in_dest = 5'd31; in_data = 64'hFFFF;
    settle();
    check("z_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    settle();
    check("z_count",   64'(count), 64'd0);
    check("z_write",   64'(rf_write), 64'd0);
    check("z_pending", 64'(pending), 64'd0);

    // Fill under hold, then check backpressure and drain order
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 64'(16'h100 + i));
    settle();
    check("full_count",   64'(count), 64'd4);
    check("full_ready",   64'(in_ready), 64'd0);
    check("full_pending", 64'(pending), 64'h1E);
    check("full_hold_wr", 64'(rf_write), 64'd0);
    check("full_head",    64'(rf_select), 64'd1);
    push(5'd9, 64'h999);
    check("full_reject_count",   64'(count), 64'd4);
    check("full_reject_pending", 64'(pending), 64'h1E);
    hold = 1'b0;
    settle();
    for (int i = 1; i <= 4; i++) begin
      check("drain_write",  64'(rf_write), 64'd1);
      check("drain_select", 64'(rf_select), 64'(i));
      check("drain_data",   rf_data, 64'(16'h100 + i));
      tick();
    end
    check("drain_count", 64'(count), 64'd0);
    check("drain_idle",  64'(rf_write), 64'd0);

    // Simultaneous accept and pop keeps count steady
    push(5'd2, 64'h22);
    in_valid = 1'b1; in_dest = 5'd3; in_data = 64'h33;
    tick();
    in_valid = 1'b0;
    settle();
    check("simul_count",  64'(count), 64'd1);
    check("simul_select", 64'(rf_select), 64'd3);
    check("simul_data",   rf_data, 64'h33);
    tick();
    check("simul_empty", 64'(count), 64'd0);

    // Same destination: acceptance order, pending held until last pops
    hold = 1'b1;
    push(5'd7, 64'hAAAA);
    push(5'd7, 64'hBBBB);
    hold = 1'b0;
    settle();
    check("same_first",    rf_data, 64'hAAAA);
    check("same_pend_a",   64'(pending), 64'h80);
    tick();
    check("same_second",   rf_data, 64'hBBBB);
    check("same_pend_b",   64'(pending), 64'h80);
    check("same_write_b",  64'(rf_write), 64'd1);
    tick();
    check("same_pend_clr", 64'(pending), 64'd0);

`ifdef FWD_EN
    // Lookup returns the youngest matching entry
    hold = 1'b1;
    push(5'd9, 64'hA);
    push(5'd9, 64'hB);
    fwd_a_sel = 5'd9; fwd_b_sel = 5'd10;
    settle();
    check("fwd_a_hit",  64'(fwd_a_hit), 64'd1);
    check("fwd_a_data", fwd_a_data, 64'hB);
    check("fwd_b_hit",  64'(fwd_b_hit), 64'd0);
    check("fwd_b_data", fwd_b_data, 64'd0);
    fwd_a_sel = 5'd31;
    settle();
    check("fwd_r31_hit", 64'(fwd_a_hit), 64'd0);
    hold = 1'b0;
    tick();
    tick();
    check("fwd_drained", 64'(count), 64'd0);
`endif

    // Reset mid-operation discards queued entries
    hold = 1'b1;
    push(5'd11, 64'h11);
    push(5'd12, 64'h12);
    push(5'd13, 64'h13);
    check("mid_count_pre", 64'(count), 64'd3);
    #2;
    reset = 1'b0;
    #1;
    check("mid_count",    64'(count), 64'd0);
    check("mid_write",    64'(rf_write), 64'd0);
    check("mid_pending",  64'(pending), 64'd0);
    check("mid_in_ready", 64'(in_ready), 64'd1);
    tick();
    reset = 1'b1;
    hold  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("mid_no_write", 64'(rf_write), 64'd0);
      tick();
    end
    check("mid_count_post", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Writer-side companion of the 32x64 register file.
- Accepts writeback requests (destination index plus 64-bit result) from execute/memory stages over a valid/ready handshake, buffers them in order, and drives the register file write port (write enable, 5-bit select, 64-bit data), at most one write per cycle.
- Exports a pending-write scoreboard so issue logic can detect hazards on queued destinations.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH); pointer width.
- CNT_W, 3, occupancy count width; holds 0..DEPTH.

Ports:
- clock  input  1  Rising-edge clock.
- reset  input  1  Asynchronous, active-low reset.
- in_valid  input  1  Writeback request valid.
- in_ready  output  1  Queue can accept; equals not full.
- in_dest  input  5  Destination register index.
- in_data  input  64  Result data.
- hold  input  1  When 1, the queue does not drain (register file port borrowed elsewhere).
- rf_write  output  1  Write enable to register file.
- rf_select  output  5  Register file data select.
- rf_data  output  64  Register file data in.
- pending  output  32  Bit i = 1 when a queued entry targets register i.
- count  output  CNT_W  Current occupancy.
- busy  output  1  1 when count is non-zero.
- fwd_a_sel, fwd_b_sel  input  5  Lookup indices (FWD_EN only).
- fwd_a_hit, fwd_b_hit  output  1  Lookup hit (FWD_EN only).
- fwd_a_data, fwd_b_data  output  64  Forwarded data (FWD_EN only).

Behaviour:
- Reset (reset = 0, asynchronous):
  - Queue empties and pointers clear.
  - Outputs: count = 0, busy = 0, rf_write = 0, rf_select = 0, rf_data = 0, pending = 0, in_ready = 1.
  - Queued entries are discarded, not written, including on reset mid-operation.
- Accept:
  - A request is accepted on a rising edge where in_valid & in_ready.
  - in_ready = (count != DEPTH). It is combinational from count only, never from in_valid or hold.
- Register 31 (hardwired zero):
  - A request with in_dest = 31 is accepted (the handshake completes) but is not enqueued.
  - count is unchanged, and the request never produces rf_write or a pending bit.
  - When full, in_ready = 0 still applies to dest-31 requests.
- Drain:
  - rf_write = busy & ~hold, combinational.
  - rf_select and rf_data show the head entry whenever busy, and 0 when empty.
  - The head pops on every rising edge where rf_write = 1; the register file captures the write on the same edge.
- Latency:
  - A request accepted at edge N, into an empty queue with hold = 0, gives rf_write = 1 during the cycle after N.
  - The register file is updated at edge N+1.
  - There is no same-cycle bypass from in_* to rf_*.
- Simultaneous accept and pop: count is unchanged and both pointers advance. This is legal at any occupancy from 1 to DEPTH-1. When full, only the pop occurs that edge.
- Order: strict FIFO. Two writes to the same register reach the register file in acceptance order, so the last write wins.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH or underflows.
- pending is combinational OR-decode of the dest fields of all valid entries. pending[31] is always 0.
- hold asserted mid-stream: the head stays stable and rf_write drops the same cycle. Accepts continue until full.

Optional Feature:
- Macro FWD_EN.
- With FWD_EN defined, the fwd_* ports exist and are combinational:
  - fwd_x_hit = 1 when any valid entry has dest equal to fwd_x_sel.
  - fwd_x_data = data of the youngest matching entry.
  - On a miss, hit = 0 and data = 0.
  - A select of 31 never hits.
  - An entry popping this cycle still counts as valid for lookup.
- Without FWD_EN, the fwd_* ports and lookup logic are absent. All other behaviour is identical.

Test Plan:
- Single write: reset, then in_dest = 5, in_data = 64'h1234 for one cycle with hold = 0. Next cycle: rf_write = 1, rf_select = 5, rf_data = 64'h1234, pending[5] = 1. One cycle later: count = 0, pending = 0.
- Zero register: in_dest = 31, in_data = 64'hFFFF. Handshake completes, count stays 0, rf_write never asserts, pending = 0.
- Full and backpressure: hold = 1, enqueue dests 1,2,3,4. Then count = 4, in_ready = 0, a fifth request is not accepted, pending = 32'h1E. Release hold: rf_write for four consecutive cycles with selects 1,2,3,4 in order.
- Same-destination ordering: enqueue dest 7 data A, then dest 7 data B. rf_data = A then B on consecutive write cycles. pending[7] clears only after B pops.
- Reset mid-operation: three entries queued with hold = 1, pulse reset low between edges. Immediately count = 0, rf_write = 0, pending = 0, in_ready = 1. Nothing is written after reset releases.
- FWD_EN: hold = 1, queue dest 9 = 64'hA, then dest 9 = 64'hB. fwd_a_sel = 9 gives hit = 1, data = 64'hB. fwd_b_sel = 10 gives hit = 0, data = 0. fwd_a_sel = 31 gives hit = 0.
